mac_rx_frame_ctrl: RTL

Sequences the GMII receive datapath once the preamble/SFD detector flags a frame start. Forwards payload bytes (destination address through FCS) as a byte stream, delimits the frame end, and classifies each frame as good, runt, oversize or errored. Drives the detector's `last_byte_sent` and `error` inputs and keeps per-frame length and good/bad frame statistics. Sits between the preamble/SFD detector and the MAC RX FCS/filter stage, all in the GMII RX clock domain.

---
 rtl/mac_rx_frame_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mac_rx_frame_ctrl.sv
// GMII receive frame sequencer: forwards payload bytes one cycle behind a hold register,
// tags the final beat, classifies frames (good/runt/oversize/errored) and keeps statistics.
module mac_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic             mac_gmii_rx_clk,
  input  logic             mac_gmii_rx_rstn,
  input  logic [7:0]       mac_gmii_rxd,
  input  logic             mac_gmii_rx_dv,
  input  logic             mac_gmii_rx_er,
  input  logic             preamble_sfd_valid,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             last_byte_sent,
  output logic             error,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_len_valid,
  output logic [CNT_W-1:0] stat_good_cnt,
  output logic [CNT_W-1:0] stat_bad_cnt
);

  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             lbs_q, lbs_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic             flen_vld_q, flen_vld_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    len_d      = len_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    lbs_d      = 1'b0;
    err_d      = 1'b0;
    flen_d     = flen_q;
    flen_vld_d = 1'b0;
    good_d     = good_q;
    bad_d      = bad_q;

    unique case (state_q)
      IDLE: begin
        if (preamble_sfd_valid && mac_gmii_rx_dv && !mac_gmii_rx_er) begin
          hold_d  = mac_gmii_rxd;
          len_d   = LEN_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        // Every RECV cycle releases the held byte; only its tagging differs.
        tdata_d  = hold_q;
        tvalid_d = 1'b1;
        if (!mac_gmii_rx_dv) begin
          tlast_d    = 1'b1;
          flen_d     = len_q;
          flen_vld_d = 1'b1;
          state_d    = IDLE;
          if (len_q < MinLen) begin
            tuser_d = 1'b1;
            err_d   = 1'b1;
            bad_d   = bad_q + CNT_W'(1);
          end else begin
            lbs_d  = 1'b1;
            good_d = good_q + CNT_W'(1);
          end
        end else if (mac_gmii_rx_er || (len_q == MaxLen)) begin
          // Receive error or one byte too many: the incoming byte is dropped.
          tlast_d    = 1'b1;
          tuser_d    = 1'b1;
          err_d      = 1'b1;
          flen_d     = len_q;
          flen_vld_d = 1'b1;
          bad_d      = bad_q + CNT_W'(1);
          state_d    = DROP;
        end else begin
          hold_d = mac_gmii_rxd;
          len_d  = len_q + LEN_W'(1);
        end
      end
      DROP: begin
        if (!mac_gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
    if (!mac_gmii_rx_rstn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      len_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      lbs_q      <= 1'b0;
      err_q      <= 1'b0;
      flen_q     <= '0;
      flen_vld_q <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      len_q      <= len_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      lbs_q      <= lbs_d;
      err_q      <= err_d;
      flen_q     <= flen_d;
      flen_vld_q <= flen_vld_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign last_byte_sent  = lbs_q;
  assign error           = err_q;
  assign frame_len       = flen_q;
  assign frame_len_valid = flen_vld_q;
  assign stat_good_cnt   = good_q;
  assign stat_bad_cnt    = bad_q;

endmodule
